// File: rtl/fork_cond_nch_r1_2ph.sv
// -----------------------------------------------------------------------------
// fork_cond_nch_r1_2ph
//
// Clocked N-channel conditional fork for single-rail 2-phase (transition)
// channels. One input token (r/a handshake plus data_in) is forwarded to the
// subset of output channels selected by cond. The input acknowledge a toggles
// only after every selected channel has acknowledged.
//
// A 2-phase channel has a token pending when its request differs from its
// acknowledge. Issuing a token means toggling the request. Acknowledging a token
// means toggling the acknowledge.
//
// Parameters
//   NCH    number of output channels (>= 1)
//   WIDTH  data width in bits
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous reset, active-high
//   r         input request (token pending when r != a)
//   a         input acknowledge, toggles once per consumed token
//   data_in   input data, valid while the input token is pending
//   cond      per-channel select, sampled together with the token
//   r_ch      per-channel request; bit i toggles to issue on channel i
//   a_ch      per-channel acknowledge; channel i idle when a_ch[i] == r_ch[i]
//   data_out  registered copy of data_in, held from fork until a toggles
//   busy      1 while waiting for the selected channels to acknowledge
//   err       sticky protocol-error flag, cleared only by rst
//
// Optional build macro
//   FORK_COND_SYNC_EN  when defined, r and every a_ch[i] pass through 2-flop
//                      synchronisers before use. Both handshake latencies then
//                      grow from 1 to 3 cycles. err is judged on the
//                      synchronised values.
// -----------------------------------------------------------------------------
module fork_cond_nch_r1_2ph #(
  parameter int NCH   = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r,
  output logic             a,
  input  logic [WIDTH-1:0] data_in,
  input  logic [NCH-1:0]   cond,
  output logic [NCH-1:0]   r_ch,
  input  logic [NCH-1:0]   a_ch,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             err
);

  // ---------------------------------------------------------------------------
  // Handshake input conditioning
  // ---------------------------------------------------------------------------
  logic           r_use;
  logic [NCH-1:0] a_ch_use;

`ifdef FORK_COND_SYNC_EN
  // The synchronisers reset to 0. This matches the environment's
  // return-to-zero after a reset, so no phantom token or acknowledge appears.
  logic [1:0] r_sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_reg <= 2'b00;
    end else begin
      r_sync_reg <= {r_sync_reg[0], r};
    end
  end

  assign r_use = r_sync_reg[1];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ack_sync
      logic [1:0] ack_sync_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          ack_sync_reg <= 2'b00;
        end else begin
          ack_sync_reg <= {ack_sync_reg[0], a_ch[gi]};
        end
      end

      assign a_ch_use[gi] = ack_sync_reg[1];
    end
  endgenerate
`else
  assign r_use    = r;
  assign a_ch_use = a_ch;
`endif

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_reg;
  logic             a_reg;
  logic [NCH-1:0]   r_ch_reg;
  logic [NCH-1:0]   mask_reg;
  logic [WIDTH-1:0] data_reg;
  logic             busy_reg;
  logic             err_reg;

  // ---------------------------------------------------------------------------
  // Per-edge observations
  // ---------------------------------------------------------------------------
  logic           in_pending;   // input token waiting to be forked
  logic [NCH-1:0] outstanding;  // channels whose token is not yet acknowledged
  logic [NCH-1:0] stray_ack;    // activity on channels this token did not select
  logic           all_idle;
  logic           cond_any;

  assign in_pending  = r_use ^ a_reg;
  assign outstanding = r_ch_reg ^ a_ch_use;
  assign stray_ack   = outstanding & ~mask_reg;
  assign all_idle    = (outstanding == '0);
  assign cond_any    = (cond != '0);

  // Protocol errors.
  // In IDLE, every channel must be idle; any difference is a spurious
  // acknowledge. In BUSY, only the channels chosen at fork time may have a
  // token outstanding. These flags never influence sequencing.
  logic err_set;

  always_comb begin
    err_set = 1'b0;
    case (state_reg)
      ST_IDLE: err_set = !all_idle;
      ST_BUSY: err_set = (stray_ack != '0);
      default: err_set = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fork sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= 1'b0;
      r_ch_reg  <= '0;
      mask_reg  <= '0;
      data_reg  <= '0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= err_reg | err_set;

      case (state_reg)
        ST_IDLE: begin
          if (in_pending) begin
            // Latch cond and data with the token. Later changes on those
            // inputs cannot disturb a fork already in flight.
            mask_reg <= cond;
            data_reg <= data_in;
            r_ch_reg <= r_ch_reg ^ cond;
            if (cond_any) begin
              busy_reg  <= 1'b1;
              state_reg <= ST_BUSY;
            end else begin
              // Nothing selected: consume the token immediately.
              a_reg <= ~a_reg;
            end
          end
        end

        ST_BUSY: begin
          // Completion needs every channel idle, not only the masked ones.
          // A stray acknowledge on an unselected channel therefore holds off
          // a until it is withdrawn, and it is also flagged in err.
          // An extra r toggle seen here is ignored. It becomes pending only
          // after a toggles and the sequencer is back in IDLE.
          if (all_idle) begin
            a_reg     <= ~a_reg;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from registers
  // ---------------------------------------------------------------------------
  assign a        = a_reg;
  assign r_ch     = r_ch_reg;
  assign data_out = data_reg;
  assign busy     = busy_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_fork_cond_nch_r1_2ph.sv
// -----------------------------------------------------------------------------
// Directed testbench for fork_cond_nch_r1_2ph with NCH=4 and WIDTH=8.
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge before new stimulus is applied.
// -----------------------------------------------------------------------------
module tb_fork_cond_nch_r1_2ph;

  localparam int NCH   = 4;
  localparam int WIDTH = 8;

`ifdef FORK_COND_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  // ---------------------------------------------------------------------------
  // DUT connections
  // ---------------------------------------------------------------------------
  logic             clk;
  logic             rst;
  logic             r;
  logic             a;
  logic [WIDTH-1:0] data_in;
  logic [NCH-1:0]   cond;
  logic [NCH-1:0]   r_ch;
  logic [NCH-1:0]   a_ch;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             err;

  fork_cond_nch_r1_2ph #(
    .NCH   (NCH),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .r        (r),
    .a        (a),
    .data_in  (data_in),
    .cond     (cond),
    .r_ch     (r_ch),
    .a_ch     (a_ch),
    .data_out (data_out),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Check counters and the single checking task
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Transition monitor: counts toggles on each r_ch bit and on a
  // ---------------------------------------------------------------------------
  int             rch_tog [NCH];
  int             a_tog = 0;
  logic [NCH-1:0] rch_prev = '0;
  logic           a_prev = 1'b0;

  initial begin
    for (int i = 0; i < NCH; i++) rch_tog[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (r_ch[i] !== rch_prev[i]) rch_tog[i]++;
    end
    if (a !== a_prev) a_tog++;
    rch_prev = r_ch;
    a_prev   = a;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [NCH-1:0]   exp_rch;
  logic             exp_a;
  logic [NCH-1:0]   t4_cond [8];
  logic [WIDTH-1:0] t4_data [8];
  int               snap_rch [NCH];
  int               snap_a;
  int               exp_cnt;
  bit               done;

  initial begin
    t4_cond = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h3, 4'hC, 4'h0};
    t4_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // ---- 1. Reset with r held high --------------------------------------
    rst     = 1'b1;
    r       = 1'b1;
    cond    = 4'b0001;
    data_in = 8'h3C;
    a_ch    = '0;
    tick(3);
    check_val("t1_rst_a",    a,        0);
    check_val("t1_rst_rch",  r_ch,     0);
    check_val("t1_rst_data", data_out, 0);
    check_val("t1_rst_busy", busy,     0);
    check_val("t1_rst_err",  err,      0);
    rst = 1'b0;
    tick(LAT);
    exp_rch = 4'b0001;
    exp_a   = 1'b0;
    check_val("t1_fork_rch",  r_ch,     exp_rch);
    check_val("t1_fork_data", data_out, 8'h3C);
    check_val("t1_fork_busy", busy,     1);
    a_ch[0] = 1'b1;
    tick(LAT);
    exp_a = 1'b1;
    check_val("t1_ack_a",    a,    exp_a);
    check_val("t1_ack_busy", busy, 0);

    // ---- 2. Basic fork --------------------------------------------------
    r       = ~r;
    cond    = 4'b0101;
    data_in = 8'hA5;
    tick(LAT);
    exp_rch = exp_rch ^ 4'b0101;
    check_val("t2_rch",  r_ch,     exp_rch);
    check_val("t2_data", data_out, 8'hA5);
    check_val("t2_busy", busy,     1);
    cond    = 4'b1111;  // changes during BUSY must be ignored
    data_in = 8'h00;
    a_ch[0] = exp_rch[0];
    tick(3);
    check_val("t2_wait_busy", busy,     1);
    check_val("t2_wait_a",    a,        exp_a);
    check_val("t2_hold_data", data_out, 8'hA5);
    a_ch[2] = exp_rch[2];
    tick(LAT - 1);
    check_val("t2_pre_a", a, exp_a);
    tick(1);
    exp_a = ~exp_a;
    check_val("t2_done_a",    a,    exp_a);
    check_val("t2_done_busy", busy, 0);
    check_val("t2_err",       err,  0);

    // ---- 3. Drop --------------------------------------------------------
    r       = ~r;
    cond    = 4'b0000;
    data_in = 8'h5A;
    tick(LAT);
    exp_a = ~exp_a;
    check_val("t3_a",    a,    exp_a);
    check_val("t3_rch",  r_ch, exp_rch);
    check_val("t3_busy", busy, 0);

    // ---- 4. Back-to-back tokens with instant consumers -------------------
    tick(1);
    for (int i = 0; i < NCH; i++) snap_rch[i] = rch_tog[i];
    snap_a = a_tog;
    for (int t = 0; t < 8; t++) begin
      r       = ~r;
      cond    = t4_cond[t];
      data_in = t4_data[t];
      done    = 0;
      for (int k = 0; k < 20; k++) begin
        tick(1);
        a_ch = r_ch;
        if (a == r) begin
          done = 1;
          break;
        end
      end
      exp_rch = exp_rch ^ t4_cond[t];
      check_val($sformatf("t4_done%0d", t), done,     1);
      check_val($sformatf("t4_rch%0d", t),  r_ch,     exp_rch);
      check_val($sformatf("t4_data%0d", t), data_out, t4_data[t]);
    end
    tick(1);
    check_val("t4_a_tog", a_tog - snap_a, 8);
    for (int i = 0; i < NCH; i++) begin
      exp_cnt = 0;
      for (int t = 0; t < 8; t++) exp_cnt += int'(t4_cond[t][i]);
      check_val($sformatf("t4_rch_tog%0d", i), rch_tog[i] - snap_rch[i], exp_cnt);
    end
    check_val("t4_err", err, 0);
    exp_a = a;  // a has toggled 8 times since it was last tracked

    // ---- 5. Protocol errors -----------------------------------------------
    a_ch[1] = ~a_ch[1];
    tick(LAT);
    check_val("t5_idle_err", err, 1);
    tick(2);
    check_val("t5_sticky_err", err, 1);
    a_ch[1] = ~a_ch[1];
    tick(LAT + 1);
    r       = ~r;
    cond    = 4'b0001;
    data_in = 8'h77;
    tick(LAT);
    exp_rch = exp_rch ^ 4'b0001;
    check_val("t5_rch",  r_ch, exp_rch);
    check_val("t5_busy", busy, 1);
    a_ch[3] = ~a_ch[3];
    tick(1);
    a_ch[3] = ~a_ch[3];
    tick(LAT + 1);
    check_val("t5_busy_err",  err,  1);
    check_val("t5_still_busy", busy, 1);
    a_ch[0] = exp_rch[0];
    tick(LAT);
    exp_a = ~exp_a;
    check_val("t5_done_a",    a,    exp_a);
    check_val("t5_done_busy", busy, 0);
    check_val("t5_done_err",  err,  1);

    // ---- 6. Reset during BUSY -------------------------------------------
    r       = ~r;
    cond    = 4'b0110;
    data_in = 8'hC3;
    tick(LAT);
    check_val("t6_busy", busy, 1);
    rst = 1'b1;
    tick(1);
    check_val("t6_rst_a",    a,        0);
    check_val("t6_rst_rch",  r_ch,     0);
    check_val("t6_rst_data", data_out, 0);
    check_val("t6_rst_busy", busy,     0);
    check_val("t6_rst_err",  err,      0);
    r    = 1'b0;
    a_ch = '0;
    tick(1);
    rst = 1'b0;
    tick(LAT + 2);
    check_val("t6_post_a",    a,    0);
    check_val("t6_post_busy", busy, 0);
    check_val("t6_post_err",  err,  0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
